down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
//
// PURPOSE
//   Loadable synchronous down counter with terminal-count pulse and optional
//   auto-reload. It is the counting-down counterpart of the ripple carry
//   (up) counter. It is used as a programmable interval timer / event divider
//   beside the up counter in the same clock domain. Fully synchronous counting:
//   all state bits change on the same clk edge (no rippled clocks).
//
// PARAMETERS
//   WIDTH     4    counter width in bits (>= 2)
//
// PORTS
//   clk          input   1      system clock, rising edge
//   reset        input   1      asynchronous, active-low reset
//   abort        input   1      synchronous stop: clear count, go idle, no tc
//   load         input   1      synchronous load strobe
//   load_value   input   WIDTH  start value captured on load
//   enable       input   1      count qualifier; one decrement per enabled cycle
//   auto_reload  input   1      1 = reload from captured value on expiry
//   q            output  WIDTH  current count (registered)
//   tc           output  1      terminal-count pulse (registered, 1 cycle)
//   busy         output  1      1 while in RUN state (registered)
//
// BEHAVIOUR
//   Reset (reset=0, async, no clock needed):
//     q=0, tc=0, busy=0, reload_reg=0, state=IDLE.
//   States:
//     IDLE: holds q; enable ignored.
//     RUN: counts down.
//   Per-edge priority: abort > load > enable.
//   abort=1:
//     q<=0, state<=IDLE, tc<=0; reload_reg unchanged.
//   load=1 (any state):
//     q<=load_value, reload_reg<=load_value, tc<=0.
//     state<=RUN if load_value!=0, else IDLE.
//     No decrement on the load edge, even if enable=1.
//   RUN, enable=1, q>1:
//     q<=q-1, tc<=0.
//   RUN, enable=1, q==1 (expiry):
//     tc<=1 for exactly one cycle.
//     If auto_reload=1: q<=reload_reg, stay RUN; period = reload_reg enabled cycles.
//     Else: q<=0, state<=IDLE.
//   RUN, enable=0:
//     q holds, tc<=0.
//   tc default:
//     0 on every edge not listed above.
//     Never asserts from IDLE, abort, or load.
//   busy:
//     busy==(state==RUN).
//     Drops on the same edge that q reaches 0 (non-reload) or on abort.
//   Width rule:
//     q never underflows; no wrap from 0 to 2^WIDTH-1 under any input sequence.
//   auto_reload is sampled only at the expiry edge; it may change mid-count.
//   reset asserted mid-count aborts immediately; it is released synchronously
//   to clk by the system reset tree.
//
// TESTING  (WIDTH=4)
//   1 In RUN at q=5, drop reset between edges -> q=0, busy=0, tc=0 at once,
//     before any clk edge.
//   2 load_value=3, then enable=1 steady, auto_reload=0 -> q 3,2,1,0.
//     tc=1 only in the cycle q=0. busy 1->0 on that edge. q stays 0 afterwards.
//   3 auto_reload=1, load_value=2, enable=1 steady -> q 2,1,2,1,...
//     tc pulses on every q 1->2 edge (every 2 cycles). busy stays 1.
//   4 q=7 in RUN with load=1, load_value=9, enable=1 -> q=9 (no decrement).
//     abort=1 with load=1 -> q=0, busy=0, tc=0.
//   5 enable pattern 1,0,0,1 from q=4 -> q 3,3,3,2.
//     IDLE at q=0 with enable=1 for 10 cycles -> q=0, tc never asserts.
//   6 load_value=0 -> q=0, busy=0, no tc.
//     load_value=15 (max), enable steady -> 15 decrements to 0, single tc pulse,
//     no wrap.

Source files
------------

// File: rtl/down_counter_timer.sv
// Loadable down counter / interval timer with one-cycle terminal-count pulse and optional auto-reload.
// Outputs are registered and change one edge after the cause. There is no backpressure; enable qualifies each decrement.
module down_counter_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             abort,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             busy
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] reload_reg, reload_nxt;
   logic             tc_nxt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         q          <= '0;
         reload_reg <= '0;
         tc         <= 1'b0;
      end else begin
         state      <= state_nxt;
         q          <= q_nxt;
         reload_reg <= reload_nxt;
         tc         <= tc_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      q_nxt      = q;
      reload_nxt = reload_reg;
      tc_nxt     = 1'b0;
      if (abort) begin
         q_nxt     = '0;
         state_nxt = IDLE;
      end else if (load) begin
         q_nxt      = load_value;
         reload_nxt = load_value;
         state_nxt  = (load_value != '0) ? RUN : IDLE;
      end else if (state == RUN && enable) begin
         if (q > WIDTH'(1)) begin
            q_nxt = q - WIDTH'(1);
         end else if (q == WIDTH'(1)) begin
            tc_nxt = 1'b1;
            if (auto_reload) begin
               q_nxt = reload_reg;
            end else begin
               q_nxt     = '0;
               state_nxt = IDLE;
            end
         end else begin
            // Zero count while running is unreachable; park safely rather than wrap.
            state_nxt = IDLE;
         end
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed and randomized checks of down_counter_timer against a behavioural timer model.
module tb_down_counter_timer;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset, abort, load, enable, auto_reload;
   logic [W-1:0] load_value;
   logic [W-1:0] q;
   logic         tc, busy;

   int total  = 0;
   int passes = 0;

   // Behavioural model: the remaining count, whether a timing interval is in
   // progress, the last programmed period and the expiry flag.
   int m_q, m_period, m_tc;
   bit m_running;

   down_counter_timer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .abort(abort), .load(load),
      .load_value(load_value), .enable(enable), .auto_reload(auto_reload),
      .q(q), .tc(tc), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic void model_edge();
      m_tc = 0;
      if (abort) begin
         m_q = 0;
         m_running = 0;
      end else if (load) begin
         m_q = int'(load_value);
         m_period = int'(load_value);
         m_running = (load_value != 0);
      end else if (m_running && enable) begin
         if (m_q > 1) begin
            m_q = m_q - 1;
         end else begin
            m_tc = 1;
            if (auto_reload) m_q = m_period;
            else begin
               m_q = 0;
               m_running = 0;
            end
         end
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("model q", 32'(q), 32'(m_q));
      chk("model tc", 32'(tc), 32'(m_tc));
      chk("model busy", 32'(busy), 32'(m_running));
   endtask

   task automatic chk_out(input string tag, input int eq, input int etc, input int ebusy);
      chk({tag, " q"}, 32'(q), 32'(eq));
      chk({tag, " tc"}, 32'(tc), 32'(etc));
      chk({tag, " busy"}, 32'(busy), 32'(ebusy));
   endtask

   initial begin
      int exp_q2[5];
      int exp_tc2[5];
      int tc_count;
      exp_q2  = '{2, 1, 0, 0, 0};
      exp_tc2 = '{0, 0, 1, 0, 0};

      reset = 1'b0; abort = 1'b0; load = 1'b0; enable = 1'b0;
      auto_reload = 1'b0; load_value = '0;
      m_q = 0; m_period = 0; m_tc = 0; m_running = 0;
      #12;
      chk_out("reset", 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      // Async reset mid-count takes effect between edges
      load_value = 4'd5; load = 1'b1;
      cyc();
      chk_out("load5", 5, 0, 1);
      load = 1'b0;
      #3;
      reset = 1'b0;
      #1;
      m_q = 0; m_period = 0; m_tc = 0; m_running = 0;
      chk_out("async reset", 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;

      // One-shot from 3
      load_value = 4'd3; load = 1'b1; enable = 1'b1;
      cyc();
      chk_out("load3", 3, 0, 1);
      load = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk_out("oneshot", exp_q2[i], exp_tc2[i], (exp_q2[i] != 0) ? 1 : 0);
      end

      // Auto-reload period 2
      auto_reload = 1'b1; load_value = 4'd2; load = 1'b1;
      cyc();
      chk_out("reload load", 2, 0, 1);
      load = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk_out("reload", (i % 2 == 0) ? 1 : 2, (i % 2 == 1) ? 1 : 0, 1);
      end

      // Load beats enable; abort beats load
      auto_reload = 1'b0; enable = 1'b0; load_value = 4'd7; load = 1'b1;
      cyc();
      load_value = 4'd9; enable = 1'b1;
      cyc();
      chk_out("reload over run", 9, 0, 1);
      abort = 1'b1;
      cyc();
      chk_out("abort", 0, 0, 0);
      abort = 1'b0; load = 1'b0;

      // Enable gating from 4
      load_value = 4'd4; load = 1'b1; enable = 1'b0;
      cyc();
      load = 1'b0;
      enable = 1'b1; cyc(); chk_out("gate1", 3, 0, 1);
      enable = 1'b0; cyc(); chk_out("gate2", 3, 0, 1);
      cyc(); chk_out("gate3", 3, 0, 1);
      enable = 1'b1; cyc(); chk_out("gate4", 2, 0, 1);
      abort = 1'b1; cyc(); abort = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk_out("idle enable", 0, 0, 0);
      end

      // Zero load and full-range count
      load_value = 4'd0; load = 1'b1;
      cyc();
      chk_out("load0", 0, 0, 0);
      load_value = 4'd15;
      cyc();
      chk_out("load15", 15, 0, 1);
      load = 1'b0;
      tc_count = 0;
      for (int i = 0; i < 17; i++) begin
         cyc();
         if (tc === 1'b1) tc_count++;
         if (i < 15) chk_out("max count", 14 - i, (i == 14) ? 1 : 0, (i < 14) ? 1 : 0);
         else chk_out("max no wrap", 0, 0, 0);
      end
      chk("max tc pulses", 32'(tc_count), 32'd1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         abort       = ($urandom_range(0, 19) == 0);
         load        = ($urandom_range(0, 9) == 0);
         enable      = ($urandom_range(0, 3) != 0);
         auto_reload = $urandom_range(0, 1);
         load_value  = W'($urandom_range(0, 15));
         cyc();
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
